uart_tx: RTL and testbench

//   UART 8N1 transmitter: the send side of the UART link whose receive side feeds the SIPO/pattern-match path.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 27 ++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX sides: frame states, line level, bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS_DEF = 8;
  localparam logic LINE_IDLE     = 1'b1;

  // Clocks per serial bit; integer division, callers must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB-first, one start and one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BCW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_e          state, state_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 tx_nxt;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_nxt;
`endif

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = ~tx_ready;

  // Counter is held at zero while idle, so it starts fresh with the start bit.
  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_nxt   = ST_START;
          shreg_nxt   = tx_data;
          bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          par_nxt     = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          tx_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Line level is derived from the upcoming state so tx comes straight off a flop.
    case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_nxt = par_nxt;
`endif
      default:   tx_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tx      <= LINE_IDLE;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
    par   <= par_nxt;
`endif
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4; line waveforms checked against a per-cycle frame model.
module tb_uart_tx;

  localparam int CLK_FREQ  = 40;
  localparam int BAUD      = 10;
  localparam int DATA_BITS = 8;
  localparam int CPB       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = DATA_BITS + 2 + PAR;
  localparam int FL    = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, tx_busy, tx_done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // Expected line level for each clock of a frame, index 0 = first clock after the handshake.
  function automatic logic [63:0] model_line(input logic [7:0] b);
    logic [63:0] v;
    int          bi;
    v = '0;
    for (int k = 0; k < FL; k++) begin
      bi = k / CPB;
      if (bi == 0)                              v[k] = 1'b0;
      else if (bi <= DATA_BITS)                 v[k] = b[bi-1];
      else if (PAR == 1 && bi == DATA_BITS + 1) v[k] = ^b;
      else                                      v[k] = 1'b1;
    end
    return v;
  endfunction

  // Loopback receiver: samples each data bit at mid-period.
  function automatic logic [7:0] rx_decode(input logic [63:0] line);
    logic [7:0] r;
    for (int i = 0; i < DATA_BITS; i++) r[i] = line[(1 + i) * CPB + CPB / 2];
    return r;
  endfunction

  function automatic logic [63:0] fl_mask();
    return (64'd1 << FL) - 64'd1;
  endfunction

  task automatic start_frame(input logic [7:0] b, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    @(negedge clk);
    while (tx_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (tx_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL start_timeout tx_ready=%b required 1", tx_ready);
      ok = 1'b0;
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic capture(input bit drop_valid, input logic [7:0] hold_data, input int inj_at,
                         output logic [63:0] line_v, output logic [63:0] done_v,
                         output logic [63:0] busy_v);
    line_v = '0;
    done_v = '0;
    busy_v = '0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      line_v[k] = tx;
      done_v[k] = tx_done;
      busy_v[k] = tx_busy;
      if (k == 0) begin
        if (drop_valid) tx_valid = 1'b0;
        else            tx_data  = hold_data;
      end
      if (k == inj_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end
      if (k == inj_at + 1) tx_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx got=%b exp=1", tx); end
    tests_run++;
    if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    tests_run++;
    if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    tests_run++;
    if (tx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", tx_done); end
  endtask

  task automatic test_single();
    logic [7:0]  b;
    logic [63:0] line_v, done_v, busy_v, exp_v, sampled;
    bit          ok;
    for (int n = 0; n < 5; n++) begin
      b = (n == 0) ? 8'h06 : 8'($urandom_range(0, 255));
      start_frame(b, ok);
      if (ok) begin
        capture(1'b1, 8'h00, -10, line_v, done_v, busy_v);
        exp_v = model_line(b);
        tests_run++;
        if (line_v !== exp_v) begin
          tests_failed++;
          $display("FAIL single_line byte=%h got=%h exp=%h", b, line_v, exp_v);
        end
        tests_run++;
        if (done_v !== (64'd1 << (FL - 1))) begin
          tests_failed++;
          $display("FAIL single_done byte=%h got=%h exp=%h", b, done_v, 64'd1 << (FL - 1));
        end
        tests_run++;
        if (busy_v !== fl_mask()) begin
          tests_failed++;
          $display("FAIL single_busy byte=%h got=%h exp=%h", b, busy_v, fl_mask());
        end
        tests_run++;
        if (rx_decode(line_v) !== b) begin
          tests_failed++;
          $display("FAIL single_rx got=%h exp=%h", rx_decode(line_v), b);
        end
        if (n == 0 && PAR == 0) begin
          sampled = '0;
          for (int i = 0; i < 10; i++) sampled[i] = line_v[i * CPB + CPB / 2];
          tests_run++;
          if (sampled !== 64'b10_0000_1100) begin
            tests_failed++;
            $display("FAIL single_06_bits got=%b exp=1000001100", sampled[9:0]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] l1, d1, b1, l2, d2, b2;
    bit          ok;
    start_frame(8'hA5, ok);
    if (ok) begin
      capture(1'b0, 8'h3C, -10, l1, d1, b1);
      @(negedge clk);
      tests_run++;
      if (tx !== 1'b1 || tx_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_gap tx=%b ready=%b exp tx=1 ready=1", tx, tx_ready);
      end
      @(posedge clk);
      capture(1'b1, 8'h00, -10, l2, d2, b2);
      tests_run++;
      if (l1 !== model_line(8'hA5) || d1 !== (64'd1 << (FL - 1))) begin
        tests_failed++;
        $display("FAIL b2b_first line=%h done=%h exp line=%h", l1, d1, model_line(8'hA5));
      end
      tests_run++;
      if (l2 !== model_line(8'h3C)) begin
        tests_failed++;
        $display("FAIL b2b_second got=%h exp=%h", l2, model_line(8'h3C));
      end
      tests_run++;
      if (rx_decode(l1) !== 8'hA5 || rx_decode(l2) !== 8'h3C) begin
        tests_failed++;
        $display("FAIL b2b_rx got=%h,%h exp=a5,3c", rx_decode(l1), rx_decode(l2));
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [63:0] line_v, done_v, busy_v;
    bit          ok;
    start_frame(8'h06, ok);
    if (ok) begin
      capture(1'b1, 8'h00, 3 * CPB, line_v, done_v, busy_v);
      tests_run++;
      if (line_v !== model_line(8'h06)) begin
        tests_failed++;
        $display("FAIL busy_ignore got=%h exp=%h", line_v, model_line(8'h06));
      end
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (tx !== 1'b1 || tx_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_no_queue tx=%b ready=%b exp tx=1 ready=1", tx, tx_ready);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] line_v, done_v, busy_v;
    logic        pre_tx;
    int          done_seen;
    bit          ok;
    done_seen = 0;
    pre_tx    = 1'b1;
    start_frame(8'h06, ok);
    if (ok) begin
      for (int k = 0; k <= 4 * CPB + 1; k++) begin
        @(negedge clk);
        if (tx_done === 1'b1) done_seen++;
        if (k == 0) tx_valid = 1'b0;
        pre_tx = tx;
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (pre_tx !== 1'b0 || tx !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_mid_tx before=%b after=%b exp before=0 after=1", pre_tx, tx);
      end
      tests_run++;
      if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_ctrl ready=%b busy=%b exp ready=1 busy=0", tx_ready, tx_busy);
      end
      repeat (2) begin
        @(negedge clk);
        if (tx_done === 1'b1) done_seen++;
      end
      rst = 1'b0;
      repeat (FL) begin
        @(negedge clk);
        if (tx_done === 1'b1) done_seen++;
      end
      tests_run++;
      if (done_seen !== 0) begin
        tests_failed++;
        $display("FAIL rst_mid_done pulses=%0d exp=0", done_seen);
      end
      start_frame(8'h42, ok);
      if (ok) begin
        capture(1'b1, 8'h00, -10, line_v, done_v, busy_v);
        tests_run++;
        if (line_v !== model_line(8'h42) || done_v !== (64'd1 << (FL - 1))) begin
          tests_failed++;
          $display("FAIL rst_mid_next line=%h done=%h exp line=%h", line_v, done_v, model_line(8'h42));
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [63:0] line_v, done_v, busy_v;
    bit          ok;
    start_frame(8'h07, ok);
    if (ok) begin
      capture(1'b1, 8'h00, -10, line_v, done_v, busy_v);
      tests_run++;
      if (line_v[9 * CPB + 1] !== 1'b1 || done_v !== (64'd1 << 43)) begin
        tests_failed++;
        $display("FAIL parity_07 bit=%b done=%h exp bit=1 done at 43", line_v[9 * CPB + 1], done_v);
      end
    end
    start_frame(8'h06, ok);
    if (ok) begin
      capture(1'b1, 8'h00, -10, line_v, done_v, busy_v);
      tests_run++;
      if (line_v[9 * CPB + 1] !== 1'b0 || line_v !== model_line(8'h06)) begin
        tests_failed++;
        $display("FAIL parity_06 bit=%b line=%h exp bit=0", line_v[9 * CPB + 1], line_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
